mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage data-bus controller directly downstream of the EX/MEM pipeline register.
- Consumes the registered EX/MEM outputs: access type, address, store data and byte enables, load select, and the nop flag.
- Runs a request/acknowledge transaction on the external data bus and holds the pipeline stall until the access completes.
- Returns sign- or zero-extended load data toward MEM/WB.

Parameters:
- TIMEOUT_CYCLES, 255: cycles to wait in REQ for dbus_ack before aborting with bus_err. Range 1..255.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- mem_nop  in  1  bubble in MEM; suppresses any access.
- exmem_mem_r  in  1  load request.
- exmem_mem_w  in  1  store request.
- exmem_alu_res  in  32  effective byte address.
- exmem_aligned_rt_data  in  32  store data, already lane-aligned.
- mem_byte_w_en_out  in  4  store byte lane enables.
- exmem_load_sel  in  3  load type: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; 5-7 treated as LW.
- cu_stall  in  1  global stall from the control unit (another stage is stalling).
- dbus_ack  in  1  bus completion strobe; rdata is valid in the same cycle.
- dbus_rdata  in  32  read data.
- dbus_req  out  1  bus request.
- dbus_we  out  1  1 = write.
- dbus_addr  out  32  word address, {addr[31:2], 2'b00}.
- dbus_wdata  out  32  write data.
- dbus_be  out  4  byte enables; 4'b1111 for loads.
- mem_stall  out  1  stall request to the control unit.
- mem_load_data  out  32  extended load result.
- bus_err  out  1  one-cycle pulse on timeout.
- addr_err  out  1  misaligned access flag; only present with MEM_ALIGN_CHECK_EN.

Behaviour:
- States and encoding: IDLE (2'd0), REQ (2'd1), DONE (2'd2).
- "access" = (exmem_mem_r | exmem_mem_w) & ~mem_nop. If exmem_mem_r and exmem_mem_w are both set, treat it as a store.
- Reset (asynchronous, active-low): state=IDLE, counter=0. All registered outputs clear to 0: dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be, mem_load_data, bus_err, addr_err.
  - Reset mid-transaction drops dbus_req immediately; no completion is reported.
- IDLE:
  - If access, go to REQ. At the same posedge register dbus_req=1, dbus_we, dbus_addr, dbus_wdata, dbus_be, and the load_sel and addr[1:0] shadows.
  - mem_stall is combinational: 1 whenever (state==IDLE & access) or state==REQ, so the stall is raised in the detection cycle.
- REQ:
  - All dbus_* outputs stay stable until ack. dbus_ack is sampled only in REQ; an ack seen in IDLE or DONE is ignored.
  - On dbus_ack:
    - dbus_req=0.
    - For a load, mem_load_data=extend(dbus_rdata); for a store, mem_load_data is unchanged.
    - Go to DONE.
  - Counter increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES with no ack:
    - dbus_req=0, bus_err=1 for one cycle, mem_load_data=0.
    - Go to DONE.
  - Counter clears on leaving REQ.
- DONE:
  - mem_stall=0.
  - Stay in DONE while cu_stall=1, so the same EX/MEM instruction is never re-issued.
  - When cu_stall=0, go to IDLE on the next posedge. The new EX/MEM contents, latched on negedge, are evaluated in IDLE.
- Extension (little-endian), using the shadowed address bits a=addr[1:0]:
  - LB/LBU: byte a is selected, i.e. rdata[8a+7:8a]; LB sign-extends, LBU zero-extends.
  - LH/LHU: the half selected by a[1], i.e. rdata[16a[1]+15:16a[1]]; LH sign-extends, LHU zero-extends.
  - LW: rdata passed through unchanged.
- Latency: zero-wait bus (ack in the first REQ cycle) gives stall for 2 cycles (IDLE-detect + REQ). Each wait state adds one cycle.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Misaligned means LW/SW with addr[1:0]!=0, or LH/LHU/halfword store with addr[0]=1. Halfword store is detected as dbus_be of 4'b0011 or 4'b1100.
  - In IDLE, a misaligned access raises addr_err=1 for one cycle and goes straight to DONE. No bus request is issued and mem_stall is 0 in that cycle.
- Undefined: the addr_err port does not exist; misaligned addresses are issued with word-aligned dbus_addr and no check is made.

Test Plan:
- LB from addr 0x1003, rdata 0x80FF_1234, ack after 2 wait cycles -> mem_load_data=0xFFFF_FF80. mem_stall high for 4 cycles. dbus_addr=0x1000, dbus_be=4'b1111.
- SW to 0x2000, data 0xDEAD_BEEF, be 4'b1111, zero-wait ack -> dbus_we=1, dbus_wdata=0xDEAD_BEEF for exactly one REQ cycle. mem_stall high for 2 cycles.
- LHU from 0x3002, rdata 0x9ABC_0000 -> mem_load_data=0x0000_9ABC. Same access with mem_nop=1 -> dbus_req never asserted, mem_stall=0.
- No ack with TIMEOUT_CYCLES=4 -> dbus_req drops after 4 REQ cycles, bus_err pulses once, mem_load_data=0.
- reset driven low during REQ (between clock edges) -> dbus_req=0 immediately. After release, state is IDLE and a late dbus_ack has no effect.
- cu_stall=1 held for 3 cycles after an LW completes -> state stays in DONE, no second dbus_req. With MEM_ALIGN_CHECK_EN, LW at 0x4001 -> addr_err pulse and no dbus_req.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-bus controller; turns the registered EX/MEM access into one req/ack bus transaction.
// Latency: request registered one cycle after detection; zero-wait bus stalls 2 cycles, each wait state adds one.
// Backpressure: mem_stall holds the pipeline from detection until ack/timeout; DONE waits out cu_stall so nothing is re-issued.
//
// Ports: clk/reset (async, active-low); EX/MEM access inputs (mem_nop, exmem_mem_r/w, exmem_alu_res,
// exmem_aligned_rt_data, mem_byte_w_en_out, exmem_load_sel); cu_stall; dbus_* request/ack bus;
// mem_stall, mem_load_data, bus_err toward the pipeline.
// Optional macro MEM_ALIGN_CHECK_EN adds the addr_err output and rejects misaligned accesses without a bus request.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_nop,
    input  logic        exmem_mem_r,
    input  logic        exmem_mem_w,
    input  logic [31:0] exmem_alu_res,
    input  logic [31:0] exmem_aligned_rt_data,
    input  logic [3:0]  mem_byte_w_en_out,
    input  logic [2:0]  exmem_load_sel,
    input  logic        cu_stall,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    output logic        mem_stall,
    output logic [31:0] mem_load_data,
    output logic        bus_err
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        addr_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last REQ cycle without ack before the access is abandoned.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       load_sel_q;
    logic [1:0]       addr_lo_q;

    logic access;
    logic is_store;
    logic misalign;

    // A simultaneous load+store flag resolves to a store.
    assign access   = (exmem_mem_r | exmem_mem_w) & ~mem_nop;
    assign is_store = exmem_mem_w;

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        if (is_store) begin
            if (mem_byte_w_en_out == 4'b1111)
                misalign = (exmem_alu_res[1:0] != 2'b00);
            else if (mem_byte_w_en_out == 4'b0011 || mem_byte_w_en_out == 4'b1100)
                misalign = exmem_alu_res[0];
        end else begin
            case (exmem_load_sel)
                3'd1, 3'd2: misalign = 1'b0;
                3'd3, 3'd4: misalign = exmem_alu_res[0];
                default:    misalign = (exmem_alu_res[1:0] != 2'b00);
            endcase
        end
    end
`else
    assign misalign = 1'b0;
`endif

    // Raised combinationally in the detection cycle so the pipeline freezes before the request goes out.
    assign mem_stall = ((state == IDLE) & access & ~misalign) | (state == REQ);

    // Little-endian lane select plus sign/zero extension.
    function automatic logic [31:0] extend(input logic [2:0]  sel,
                                           input logic [1:0]  a,
                                           input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (sel)
            3'd1:    extend = {{24{b[7]}}, b};
            3'd2:    extend = {24'd0, b};
            3'd3:    extend = {{16{h[15]}}, h};
            3'd4:    extend = {16'd0, h};
            default: extend = rd;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            load_sel_q    <= 3'd0;
            addr_lo_q     <= 2'd0;
            dbus_req      <= 1'b0;
            dbus_we       <= 1'b0;
            dbus_addr     <= 32'd0;
            dbus_wdata    <= 32'd0;
            dbus_be       <= 4'd0;
            mem_load_data <= 32'd0;
            bus_err       <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            addr_err      <= 1'b0;
`endif
        end else begin
            // Error flags are single-cycle pulses.
            bus_err <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            addr_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (access) begin
                        if (misalign) begin
`ifdef MEM_ALIGN_CHECK_EN
                            addr_err <= 1'b1;
`endif
                            state <= DONE;
                        end else begin
                            state      <= REQ;
                            dbus_req   <= 1'b1;
                            dbus_we    <= is_store;
                            dbus_addr  <= {exmem_alu_res[31:2], 2'b00};
                            dbus_wdata <= exmem_aligned_rt_data;
                            dbus_be    <= is_store ? mem_byte_w_en_out : 4'b1111;
                            load_sel_q <= exmem_load_sel;
                            addr_lo_q  <= exmem_alu_res[1:0];
                        end
                    end
                end
                REQ: begin
                    if (dbus_ack) begin
                        dbus_req <= 1'b0;
                        cnt      <= '0;
                        state    <= DONE;
                        if (!dbus_we)
                            mem_load_data <= extend(load_sel_q, addr_lo_q, dbus_rdata);
                    end else if (cnt == TO_LAST) begin
                        dbus_req      <= 1'b0;
                        bus_err       <= 1'b1;
                        mem_load_data <= 32'd0;
                        cnt           <= '0;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // The EX/MEM register still holds the finished instruction while cu_stall is high.
                    if (!cu_stall)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_nop = 1'b0;
    logic        exmem_mem_r = 1'b0;
    logic        exmem_mem_w = 1'b0;
    logic [31:0] exmem_alu_res = 32'd0;
    logic [31:0] exmem_aligned_rt_data = 32'd0;
    logic [3:0]  mem_byte_w_en_out = 4'd0;
    logic [2:0]  exmem_load_sel = 3'd0;
    logic        cu_stall = 1'b0;
    logic        dbus_ack = 1'b0;
    logic [31:0] dbus_rdata = 32'd0;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic        mem_stall;
    logic [31:0] mem_load_data;
    logic        bus_err;
`ifdef MEM_ALIGN_CHECK_EN
    logic        addr_err;
`endif

    mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .mem_nop(mem_nop),
        .exmem_mem_r(exmem_mem_r), .exmem_mem_w(exmem_mem_w),
        .exmem_alu_res(exmem_alu_res), .exmem_aligned_rt_data(exmem_aligned_rt_data),
        .mem_byte_w_en_out(mem_byte_w_en_out), .exmem_load_sel(exmem_load_sel),
        .cu_stall(cu_stall), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .mem_stall(mem_stall),
        .mem_load_data(mem_load_data), .bus_err(bus_err)
`ifdef MEM_ALIGN_CHECK_EN
        , .addr_err(addr_err)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference: expected mem_load_data (stores leave it untouched).
    logic [31:0] model_ld;

    // Observations from the last run_access call.
    int          o_stall, o_req;
    logic [31:0] o_addr, o_wdata;
    logic [3:0]  o_be;
    logic        o_we;
    bit          o_stable, o_done;

    function automatic logic [31:0] ref_load(input logic [2:0] sel, input logic [31:0] addr,
                                             input logic [31:0] rd);
        logic [31:0] b, h;
        int          sb, shh;
        sb  = 8 * int'(addr[1:0]);
        shh = 16 * int'(addr[1]);
        b = (rd >> sb) & 32'h0000_00FF;
        h = (rd >> shh) & 32'h0000_FFFF;
        case (sel)
            3'd1:    return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return rd;
        endcase
    endfunction

    // Called at posedge+1. Presents one access, acks after 'waits' REQ cycles, returns at posedge+2 of DONE.
    task automatic run_access(input bit w, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] be, input logic [2:0] sel,
                              input logic [31:0] rd, input int waits);
        mem_nop = 1'b0; exmem_mem_r = ~w; exmem_mem_w = w;
        exmem_alu_res = addr; exmem_aligned_rt_data = wd;
        mem_byte_w_en_out = be; exmem_load_sel = sel; dbus_rdata = rd;
        o_stall = 0; o_req = 0; o_stable = 1'b1; o_done = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            #1;
            if (cyc > 0 && !mem_stall) begin
                o_done = 1'b1;
                break;
            end
            if (mem_stall) o_stall++;
            if (dbus_req) begin
                if (o_req == 0) begin
                    o_addr = dbus_addr; o_wdata = dbus_wdata; o_be = dbus_be; o_we = dbus_we;
                end else if ({dbus_addr, dbus_wdata, dbus_be, dbus_we} !== {o_addr, o_wdata, o_be, o_we}) begin
                    o_stable = 1'b0;
                end
                o_req++;
                dbus_ack = (o_req > waits);
            end
            @(posedge clk); #1;
            dbus_ack = 1'b0;
        end
    endtask

    // Retire the finished instruction: EX/MEM empties, DONE returns to IDLE. Ends at posedge+1.
    task automatic finish_access();
        exmem_mem_r = 1'b0; exmem_mem_w = 1'b0; cu_stall = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(posedge clk); @(posedge clk); #1;
        n_total++; if (dbus_req !== 1'b0) $display("FAIL rst_req: got %b exp 0", dbus_req); else n_pass++;
        n_total++; if ({dbus_we, dbus_addr, dbus_wdata, dbus_be} !== 69'd0)
            $display("FAIL rst_bus: got %b %h %h %h exp zeros", dbus_we, dbus_addr, dbus_wdata, dbus_be); else n_pass++;
        n_total++; if ({mem_load_data, bus_err, mem_stall} !== 34'd0)
            $display("FAIL rst_out: got %h %b %b exp zeros", mem_load_data, bus_err, mem_stall); else n_pass++;
        reset = 1'b1;
        model_ld = 32'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_lb();
        run_access(1'b0, 32'h0000_1003, 32'd0, 4'h0, 3'd1, 32'h80FF_1234, 2);
        n_total++; if (o_done !== 1'b1) $display("FAIL lb_done: got %b exp 1", o_done); else n_pass++;
        n_total++; if (mem_load_data !== 32'hFFFF_FF80) $display("FAIL lb_data: got %h exp ffffff80", mem_load_data); else n_pass++;
        n_total++; if (o_stall !== 4) $display("FAIL lb_stall: got %0d exp 4", o_stall); else n_pass++;
        n_total++; if (o_addr !== 32'h0000_1000) $display("FAIL lb_addr: got %h exp 00001000", o_addr); else n_pass++;
        n_total++; if (o_be !== 4'b1111) $display("FAIL lb_be: got %b exp 1111", o_be); else n_pass++;
        n_total++; if (o_req !== 3) $display("FAIL lb_req_cycles: got %0d exp 3", o_req); else n_pass++;
        model_ld = 32'hFFFF_FF80;
        finish_access();
    endtask

    task automatic test_sw();
        run_access(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'b1111, 3'd0, 32'h1357_9BDF, 0);
        n_total++; if (o_we !== 1'b1) $display("FAIL sw_we: got %b exp 1", o_we); else n_pass++;
        n_total++; if (o_wdata !== 32'hDEAD_BEEF) $display("FAIL sw_wdata: got %h exp deadbeef", o_wdata); else n_pass++;
        n_total++; if (o_req !== 1) $display("FAIL sw_req_cycles: got %0d exp 1", o_req); else n_pass++;
        n_total++; if (o_stall !== 2) $display("FAIL sw_stall: got %0d exp 2", o_stall); else n_pass++;
        n_total++; if (mem_load_data !== model_ld) $display("FAIL sw_ld_kept: got %h exp %h", mem_load_data, model_ld); else n_pass++;
        finish_access();
    endtask

    task automatic test_lhu_nop();
        bit seen;
        run_access(1'b0, 32'h0000_3002, 32'd0, 4'h0, 3'd4, 32'h9ABC_0000, 1);
        n_total++; if (mem_load_data !== 32'h0000_9ABC) $display("FAIL lhu_data: got %h exp 00009abc", mem_load_data); else n_pass++;
        model_ld = 32'h0000_9ABC;
        finish_access();
        mem_nop = 1'b1; exmem_mem_r = 1'b1; exmem_alu_res = 32'h0000_3002; exmem_load_sel = 3'd4;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (dbus_req || mem_stall) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_total++; if (seen !== 1'b0) $display("FAIL nop_quiet: got activity %b exp 0", seen); else n_pass++;
        mem_nop = 1'b0; exmem_mem_r = 1'b0;
    endtask

    task automatic test_timeout();
        run_access(1'b0, 32'h0000_5000, 32'd0, 4'h0, 3'd0, 32'hCAFE_F00D, 1000);
        n_total++; if (o_req !== 4) $display("FAIL to_req_cycles: got %0d exp 4", o_req); else n_pass++;
        n_total++; if (bus_err !== 1'b1) $display("FAIL to_err_pulse: got %b exp 1", bus_err); else n_pass++;
        n_total++; if (mem_load_data !== 32'd0) $display("FAIL to_data: got %h exp 0", mem_load_data); else n_pass++;
        model_ld = 32'd0;
        finish_access();
        n_total++; if (bus_err !== 1'b0) $display("FAIL to_err_once: got %b exp 0", bus_err); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit bad;
        model_ld = 32'h1111_2222;
        run_access(1'b0, 32'h0000_6000, 32'd0, 4'h0, 3'd0, 32'h1111_2222, 0);
        finish_access();
        mem_nop = 1'b0; exmem_mem_r = 1'b1; exmem_alu_res = 32'h0000_7000; exmem_load_sel = 3'd0;
        dbus_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        n_total++; if (dbus_req !== 1'b1) $display("FAIL rm_req_up: got %b exp 1", dbus_req); else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_total++; if (dbus_req !== 1'b0) $display("FAIL rm_req_drop: got %b exp 0", dbus_req); else n_pass++;
        exmem_mem_r = 1'b0;
        #2 reset = 1'b1;
        dbus_ack = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (dbus_req !== 1'b0 || mem_load_data !== 32'd0) bad = 1'b1;
        end
        dbus_ack = 1'b0;
        n_total++; if (bad !== 1'b0) $display("FAIL rm_late_ack: got bad=%b exp 0", bad); else n_pass++;
        model_ld = 32'd0;
        run_access(1'b0, 32'h0000_7004, 32'd0, 4'h0, 3'd0, 32'h2468_ACE0, 0);
        n_total++; if (o_stall !== 2) $display("FAIL rm_idle_after: got stall %0d exp 2", o_stall); else n_pass++;
        model_ld = 32'h2468_ACE0;
        finish_access();
    endtask

    task automatic test_cu_stall();
        bit bad;
        logic [31:0] rd;
        rd = $urandom;
        run_access(1'b0, 32'h0000_8008, 32'd0, 4'h0, 3'd0, rd, 1);
        n_total++; if (mem_load_data !== rd) $display("FAIL cs_data: got %h exp %h", mem_load_data, rd); else n_pass++;
        model_ld = rd;
        cu_stall = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            if (dbus_req !== 1'b0 || mem_stall !== 1'b0) bad = 1'b1;
        end
        n_total++; if (bad !== 1'b0) $display("FAIL cs_hold_done: got reissue=%b exp 0", bad); else n_pass++;
        finish_access();
    endtask

    task automatic test_random();
        logic [3:0]  be_tab [7] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
        for (int n = 0; n < 25; n++) begin
            bit          w;
            logic [2:0]  sel;
            logic [3:0]  be;
            logic [31:0] addr, wd, rd, exp_ld;
            int          waits;
            w = 1'($urandom_range(0, 1));
            sel = 3'($urandom_range(0, 7));
            be = be_tab[$urandom_range(0, 6)];
            addr = $urandom; wd = $urandom; rd = $urandom;
            waits = $urandom_range(0, 2);
            if (w) begin
                if (be == 4'hF) addr[1:0] = 2'b00;
                else if (be == 4'h3 || be == 4'hC) addr[0] = 1'b0;
            end else begin
                if (sel == 3'd3 || sel == 3'd4) addr[0] = 1'b0;
                else if (sel != 3'd1 && sel != 3'd2) addr[1:0] = 2'b00;
            end
            exp_ld = w ? model_ld : ref_load(sel, addr, rd);
            run_access(w, addr, wd, be, sel, rd, waits);
            n_total++; if (o_done !== 1'b1) $display("FAIL rnd%0d_done: got %b exp 1", n, o_done); else n_pass++;
            n_total++; if (mem_load_data !== exp_ld) $display("FAIL rnd%0d_data: got %h exp %h", n, mem_load_data, exp_ld); else n_pass++;
            n_total++; if (o_stall !== waits + 2) $display("FAIL rnd%0d_stall: got %0d exp %0d", n, o_stall, waits + 2); else n_pass++;
            n_total++; if (o_addr !== {addr[31:2], 2'b00}) $display("FAIL rnd%0d_addr: got %h exp %h", n, o_addr, {addr[31:2], 2'b00}); else n_pass++;
            n_total++; if (o_we !== w || o_be !== (w ? be : 4'hF))
                $display("FAIL rnd%0d_we_be: got %b/%b exp %b/%b", n, o_we, o_be, w, (w ? be : 4'hF)); else n_pass++;
            n_total++; if (o_stable !== 1'b1) $display("FAIL rnd%0d_stable: got %b exp 1", n, o_stable); else n_pass++;
            if (w) begin
                n_total++; if (o_wdata !== wd) $display("FAIL rnd%0d_wdata: got %h exp %h", n, o_wdata, wd); else n_pass++;
            end
            model_ld = exp_ld;
            finish_access();
        end
    endtask

`ifdef MEM_ALIGN_CHECK_EN
    task automatic test_align();
        mem_nop = 1'b0; exmem_mem_r = 1'b1; exmem_mem_w = 1'b0;
        exmem_alu_res = 32'h0000_4001; exmem_load_sel = 3'd0;
        #1;
        n_total++; if (mem_stall !== 1'b0) $display("FAIL al_stall: got %b exp 0", mem_stall); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (addr_err !== 1'b1) $display("FAIL al_err: got %b exp 1", addr_err); else n_pass++;
        n_total++; if (dbus_req !== 1'b0) $display("FAIL al_noreq: got %b exp 0", dbus_req); else n_pass++;
        finish_access();
        n_total++; if (addr_err !== 1'b0 || dbus_req !== 1'b0)
            $display("FAIL al_pulse: got err=%b req=%b exp 0/0", addr_err, dbus_req); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_lb();
        test_sw();
        test_lhu_nop();
        test_timeout();
        test_reset_mid();
        test_cu_stall();
        test_random();
`ifdef MEM_ALIGN_CHECK_EN
        test_align();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
